mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_tag_table.sv | 60 ++++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface definitions for the memory arbiter slice.
// Holds the types normally found in sys_defs.svh: MEM_COMMAND, MEM_TAG,
// MEM_BLOCK, ADDR and the ARB_OWNER enum used by the owner table.
// Related configuration macro (used by mem_arbiter): ARB_FAIRNESS_EN.
package mem_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [31:0] ADDR;

  typedef enum logic {
    ARB_DCACHE = 1'b0,
    ARB_ICACHE = 1'b1
  } ARB_OWNER;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory load tags.
// One entry per MEM_TAG: valid bit plus owner (dcache / icache).
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   alloc_en/tag/owner    : record a new outstanding load at the next edge
//   lookup_tag            : combinational read of the pre-edge table
//   lookup_valid/owner    : result of the lookup
//   free_en/free_tag      : retire an entry at the next edge
// When the same tag is freed and allocated in one cycle the allocation wins.
module mem_tag_table
  import mem_arbiter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc_en,
  input  MEM_TAG   alloc_tag,
  input  ARB_OWNER alloc_owner,
  input  MEM_TAG   lookup_tag,
  output logic     lookup_valid,
  output ARB_OWNER lookup_owner,
  input  logic     free_en,
  input  MEM_TAG   free_tag
);

  logic [NUM_MEM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_MEM_TAGS-1:0] owner_q, owner_d;

  // Next-state of every entry; allocation takes precedence over free.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      if (alloc_en && (alloc_tag == MEM_TAG'(i))) begin
        valid_d[i] = 1'b1;
        owner_d[i] = alloc_owner;
      end else if (free_en && (free_tag == MEM_TAG'(i))) begin
        valid_d[i] = 1'b0;
        owner_d[i] = owner_q[i];
      end else begin
        valid_d[i] = valid_q[i];
        owner_d[i] = owner_q[i];
      end
    end
  end

  // Table state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign lookup_valid = valid_q[lookup_tag];
  assign lookup_owner = ARB_OWNER'(owner_q[lookup_tag]);

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter between the dcache/MSHR and the icache.
// Picks at most one requester per cycle (dcache priority), forwards its
// command/addr/data to memory, returns the transaction tag and grant to the
// winner, and routes returning data to the owner recorded in mem_tag_table.
// Ports:
//   clock, reset                       : clock, synchronous active-high reset
//   dc_command/dc_addr/dc_data         : dcache request
//   ic_command/ic_addr                 : icache request (loads only)
//   mem2proc_*                         : memory responses
//   proc2mem_*                         : request to memory
//   dc_grant, ic_grant                 : request accepted this cycle
//   {dc,ic}_transaction_tag/data_tag/mem_data : per-requester responses
// Configuration: define ARB_FAIRNESS_EN to let a starved icache (denied for
// STARVE_LIMIT consecutive cycles) override dcache priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  MEM_COMMAND dc_command,
  input  ADDR        dc_addr,
  input  MEM_BLOCK   dc_data,
  input  MEM_COMMAND ic_command,
  input  ADDR        ic_addr,
  input  MEM_TAG     mem2proc_transaction_tag,
  input  MEM_TAG     mem2proc_data_tag,
  input  MEM_BLOCK   mem2proc_data,
  output MEM_COMMAND proc2mem_command,
  output ADDR        proc2mem_addr,
  output MEM_BLOCK   proc2mem_data,
  output logic       dc_grant,
  output logic       ic_grant,
  output MEM_TAG     dc_transaction_tag,
  output MEM_TAG     ic_transaction_tag,
  output MEM_TAG     dc_data_tag,
  output MEM_TAG     ic_data_tag,
  output MEM_BLOCK   dc_mem_data,
  output MEM_BLOCK   ic_mem_data
);

  logic     dc_req_s, ic_req_s, dc_wins_s, ic_wins_s, ic_starved_s, tag_ok_s;
  logic     alloc_en_s, lookup_valid_s, route_valid_s;
  ARB_OWNER lookup_owner_s, alloc_owner_s;

  // Winner selection and request forwarding to memory.
  always_comb begin
    dc_req_s           = (dc_command != MEM_NONE);
    ic_req_s           = (ic_command != MEM_NONE);
    ic_wins_s          = ic_req_s && (!dc_req_s || ic_starved_s);
    dc_wins_s          = dc_req_s && !ic_wins_s;
    tag_ok_s           = (mem2proc_transaction_tag != 4'd0);
    proc2mem_command   = MEM_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    dc_grant           = 1'b0;
    ic_grant           = 1'b0;
    dc_transaction_tag = 4'd0;
    ic_transaction_tag = 4'd0;
    alloc_owner_s      = ARB_DCACHE;
    if (dc_wins_s) begin
      proc2mem_command   = dc_command;
      proc2mem_addr      = dc_addr;
      proc2mem_data      = dc_data;
      dc_grant           = tag_ok_s;
      dc_transaction_tag = mem2proc_transaction_tag;
      alloc_owner_s      = ARB_DCACHE;
    end else if (ic_wins_s) begin
      proc2mem_command   = ic_command;
      proc2mem_addr      = ic_addr;
      ic_grant           = tag_ok_s;
      ic_transaction_tag = mem2proc_transaction_tag;
      alloc_owner_s      = ARB_ICACHE;
    end else begin
      proc2mem_command   = MEM_NONE;
    end
    // Only accepted loads produce a later data response worth tracking.
    alloc_en_s = (dc_grant || ic_grant) && (proc2mem_command == MEM_LOAD);
  end

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Saturating count of consecutive cycles the icache asked and was refused.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!ic_req_s || ic_grant) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign ic_starved_s = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));
`else
  logic unused_starve_limit_s;
  assign unused_starve_limit_s = (STARVE_LIMIT > 0);
  assign ic_starved_s          = 1'b0;
`endif

  mem_tag_table u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en_s),
    .alloc_tag    (mem2proc_transaction_tag),
    .alloc_owner  (alloc_owner_s),
    .lookup_tag   (mem2proc_data_tag),
    .lookup_valid (lookup_valid_s),
    .lookup_owner (lookup_owner_s),
    .free_en      (route_valid_s),
    .free_tag     (mem2proc_data_tag)
  );

  // Response routing from the pre-edge table; masked while reset is high so a
  // response for a pre-reset tag is never delivered.
  always_comb begin
    route_valid_s = !reset && (mem2proc_data_tag != 4'd0) && lookup_valid_s;
    dc_data_tag   = 4'd0;
    ic_data_tag   = 4'd0;
    dc_mem_data   = '0;
    ic_mem_data   = '0;
    if (route_valid_s && (lookup_owner_s == ARB_ICACHE)) begin
      ic_data_tag = mem2proc_data_tag;
      ic_mem_data = mem2proc_data;
    end else if (route_valid_s) begin
      dc_data_tag = mem2proc_data_tag;
      dc_mem_data = mem2proc_data;
    end else begin
      dc_data_tag = 4'd0;
    end
  end

endmodule
